// File: rtl/riscof_obi_pkg.sv
// ---------------------------------------------------------------------------
// riscof_obi_pkg
//   Shared definitions for the stalling OBI data-side responder used by the
//   RISCOF CV32E40P bench: virtual register addresses, the values that the
//   test signature writes to them, the response beat carried through the
//   latency line, and the grant FSM state encoding.
// ---------------------------------------------------------------------------
package riscof_obi_pkg;

    // Virtual registers that sit outside the RAM window
    localparam logic [31:0] PASS_FAIL_ADDR = 32'h2000_0000;
    localparam logic [31:0] EXIT_ADDR      = 32'h2000_0004;

    // Values recognised by the PASS/FAIL register; anything else is ignored
    localparam logic [31:0] PASS_VALUE     = 32'd123456789;
    localparam logic [31:0] FAIL_VALUE     = 32'd1;

    // One response beat travelling from the grant cycle to the rvalid cycle
    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } obi_rsp_t;

    // Grant stall FSM
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } gnt_state_e;

endpackage

// File: rtl/riscof_obi_rsp_delay.sv
// ---------------------------------------------------------------------------
// riscof_obi_rsp_delay
//   Fixed-latency shift line for OBI responses. A beat presented on rsp_i in
//   cycle t appears on rsp_o in cycle t+RVALID_LATENCY. Only the valid bits
//   are cleared; the data lane is free-running since it is never observed
//   without its valid bit.
//
// Ports
//   clk_i  : clock, rising edge
//   clr_i  : synchronous clear of all in-flight beats (active-high)
//   rsp_i  : response beat entering the line (valid + rdata)
//   rsp_o  : response beat leaving the line
// ---------------------------------------------------------------------------
module riscof_obi_rsp_delay
    import riscof_obi_pkg::*;
#(
    parameter int RVALID_LATENCY = 1
) (
    input  logic     clk_i,
    input  logic     clr_i,
    input  obi_rsp_t rsp_i,
    output obi_rsp_t rsp_o
);

    logic        vld_p   [RVALID_LATENCY];
    logic [31:0] rdata_p [RVALID_LATENCY];

    // Stage boundary: valid lane, cleared on reset so no stale beats survive
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < RVALID_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= rsp_i.valid;
            for (int i = 1; i < RVALID_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Stage boundary: data lane, travels beside the valid lane without reset
    always_ff @(posedge clk_i) begin
        rdata_p[0] <= rsp_i.rdata;
        for (int i = 1; i < RVALID_LATENCY; i++) begin
            rdata_p[i] <= rdata_p[i-1];
        end
    end

    assign rsp_o.valid = vld_p[RVALID_LATENCY-1];
    assign rsp_o.rdata = rdata_p[RVALID_LATENCY-1];

endmodule

// File: rtl/riscof_obi_stall_responder.sv
// ---------------------------------------------------------------------------
// riscof_obi_stall_responder
//   Data-side OBI responder for the RISCOF CV32E40P bench. Grants requests
//   after a fixed stall, performs the access at the grant edge against a
//   word-addressed RAM or the PASS/FAIL and EXIT virtual registers, and
//   returns one in-order response RVALID_LATENCY cycles after each grant.
//   At most MAX_OUTSTANDING transactions may be granted but unanswered.
//
// Parameters
//   MEM_ADDR_WIDTH : byte-address bits decoded to RAM (< 32)
//   GNT_STALL      : cycles req_i is held before gnt_o (0 = same cycle)
//   RVALID_LATENCY : grant-to-rvalid cycles, 1..8
//   MAX_OUTSTANDING: outstanding limit, 1..RVALID_LATENCY+1
//
// Ports
//   clk_i, rst_ni       : clock and synchronous active-low reset
//   req_i, addr_i, we_i, be_i, wdata_i : OBI address phase from the core
//   gnt_o               : address phase accepted (combinational)
//   rvalid_o, rdata_o   : response phase; rdata_o is 0 unless a read answers
//   tests_passed_o      : sticky, PASS value written to PASS/FAIL register
//   tests_failed_o      : sticky, FAIL value written to PASS/FAIL register
//   exit_valid_o        : sticky, EXIT register has been written
//   exit_value_o        : last value written to the EXIT register
// ---------------------------------------------------------------------------
module riscof_obi_stall_responder
    import riscof_obi_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH  = 16,
    parameter int GNT_STALL       = 0,
    parameter int RVALID_LATENCY  = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int WORDS   = 2 ** (MEM_ADDR_WIDTH - 2);
    localparam int STALL_W = (GNT_STALL < 2) ? 1 : $clog2(GNT_STALL + 1);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

    gnt_state_e          state_q, state_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [OUT_W-1:0]    out_cnt_q;
    logic                full;
    logic                gnt;

    logic                ram_sel;
    logic                pf_sel;
    logic                exit_sel;
    logic [31:0]         rd_data;
    logic [31:0]         mem [WORDS];

    obi_rsp_t            rsp_in;
    obi_rsp_t            rsp_out;

    // Byte lane bits are irrelevant for a word-addressed target
    logic                unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    // A response leaving this cycle frees its slot for a same-cycle grant
    assign full = (out_cnt_q == OUT_W'(MAX_OUTSTANDING)) && !rvalid_o;

    // -----------------------------------------------------------------------
    // Grant FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Grant FSM: next state and grant decision. The counter saturates at
    // GNT_STALL so a request blocked only by the outstanding limit is granted
    // as soon as a slot frees. Every grant returns to IDLE, so a back-to-back
    // request pays the whole stall again.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        gnt         = 1'b0;
        if (GNT_STALL == 0) begin
            gnt         = req_i && !full;
            state_d     = IDLE;
            stall_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        state_d     = WAIT;
                        stall_cnt_d = STALL_W'(1);
                    end
                end
                WAIT: begin
                    if (!req_i) begin
                        state_d     = IDLE;
                        stall_cnt_d = '0;
                    end else if (stall_cnt_q == STALL_W'(GNT_STALL)) begin
                        if (!full) begin
                            gnt         = 1'b1;
                            state_d     = IDLE;
                            stall_cnt_d = '0;
                        end
                    end else begin
                        stall_cnt_d = stall_cnt_q + STALL_W'(1);
                    end
                end
                default: begin
                    state_d     = IDLE;
                    stall_cnt_d = '0;
                end
            endcase
        end
    end

    // Nothing is accepted while reset is asserted
    assign gnt_o = gnt && rst_ni;

    // -----------------------------------------------------------------------
    // Outstanding transaction counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt_q <= '0;
        end else begin
            case ({gnt_o, rvalid_o})
                2'b10:   out_cnt_q <= out_cnt_q + OUT_W'(1);
                2'b01:   out_cnt_q <= out_cnt_q - OUT_W'(1);
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    assign ram_sel  = (addr_i[31:MEM_ADDR_WIDTH] == '0);
    assign pf_sel   = (addr_i[31:2] == PASS_FAIL_ADDR[31:2]);
    assign exit_sel = (addr_i[31:2] == EXIT_ADDR[31:2]);

    // -----------------------------------------------------------------------
    // RAM: written at the grant edge; contents survive reset
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && ram_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[addr_i[MEM_ADDR_WIDTH-1:2]][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read sees RAM before this edge's write; registers/unmapped read as 0
    always_comb begin
        rd_data = '0;
        if (!we_i && ram_sel) begin
            rd_data = mem[addr_i[MEM_ADDR_WIDTH-1:2]];
        end
    end

    // -----------------------------------------------------------------------
    // Virtual registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else if (gnt_o && we_i) begin
            if (pf_sel) begin
                if (wdata_i == PASS_VALUE) begin
                    tests_passed_o <= 1'b1;
                end else if (wdata_i == FAIL_VALUE) begin
                    tests_failed_o <= 1'b1;
                end
            end
            if (exit_sel) begin
                exit_value_o <= wdata_i;
                exit_valid_o <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response latency line: one beat per grant, cleared by reset
    // -----------------------------------------------------------------------
    assign rsp_in.valid = gnt_o;
    assign rsp_in.rdata = rd_data;

    riscof_obi_rsp_delay #(
        .RVALID_LATENCY (RVALID_LATENCY)
    ) u_rsp_delay (
        .clk_i (clk_i),
        .clr_i (!rst_ni),
        .rsp_i (rsp_in),
        .rsp_o (rsp_out)
    );

    assign rvalid_o = rsp_out.valid;
    assign rdata_o  = rsp_out.valid ? rsp_out.rdata : '0;

endmodule

// File: tb/tb_riscof_obi_stall_responder.sv
// ---------------------------------------------------------------------------
// tb_riscof_obi_stall_responder
//   Directed bench for riscof_obi_stall_responder. Three instances share the
//   address-phase inputs and reset but have their own request lines:
//     u_a : GNT_STALL=0, RVALID_LATENCY=1 (basic access, byte enables, regs)
//     u_b : GNT_STALL=3, RVALID_LATENCY=1 (grant stall behaviour)
//     u_c : GNT_STALL=0, RVALID_LATENCY=4, MAX_OUTSTANDING=2 (throttling,
//           in-order responses, reset with transactions in flight)
// ---------------------------------------------------------------------------
module tb_riscof_obi_stall_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b, req_c;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        gnt_a, rvalid_a, passed_a, failed_a, exit_valid_a;
    logic [31:0] rdata_a, exit_value_a;
    logic        gnt_b, rvalid_b, passed_b, failed_b, exit_valid_b;
    logic [31:0] rdata_b, exit_value_b;
    logic        gnt_c, rvalid_c, passed_c, failed_c, exit_valid_c;
    logic [31:0] rdata_c, exit_value_c;

    int n_cmp = 0;
    int n_err = 0;

    // Expected per-cycle behaviour of u_c for four back-to-back reads
    logic        exp_gnt [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        exp_rv  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_rd  [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hC0DE_0000, 32'hC0DE_0001,
                                  32'h0, 32'h0, 32'hC0DE_0002, 32'hC0DE_0003};

    always #5 clk = ~clk;

    riscof_obi_stall_responder #(
        .MEM_ADDR_WIDTH (16), .GNT_STALL (0), .RVALID_LATENCY (1), .MAX_OUTSTANDING (2)
    ) u_a (
        .clk_i (clk), .rst_ni (rst_n), .req_i (req_a), .addr_i (addr), .we_i (we),
        .be_i (be), .wdata_i (wdata), .gnt_o (gnt_a), .rvalid_o (rvalid_a),
        .rdata_o (rdata_a), .tests_passed_o (passed_a), .tests_failed_o (failed_a),
        .exit_valid_o (exit_valid_a), .exit_value_o (exit_value_a)
    );

    riscof_obi_stall_responder #(
        .MEM_ADDR_WIDTH (16), .GNT_STALL (3), .RVALID_LATENCY (1), .MAX_OUTSTANDING (2)
    ) u_b (
        .clk_i (clk), .rst_ni (rst_n), .req_i (req_b), .addr_i (addr), .we_i (we),
        .be_i (be), .wdata_i (wdata), .gnt_o (gnt_b), .rvalid_o (rvalid_b),
        .rdata_o (rdata_b), .tests_passed_o (passed_b), .tests_failed_o (failed_b),
        .exit_valid_o (exit_valid_b), .exit_value_o (exit_value_b)
    );

    riscof_obi_stall_responder #(
        .MEM_ADDR_WIDTH (16), .GNT_STALL (0), .RVALID_LATENCY (4), .MAX_OUTSTANDING (2)
    ) u_c (
        .clk_i (clk), .rst_ni (rst_n), .req_i (req_c), .addr_i (addr), .we_i (we),
        .be_i (be), .wdata_i (wdata), .gnt_o (gnt_c), .rvalid_o (rvalid_c),
        .rdata_o (rdata_c), .tests_passed_o (passed_c), .tests_failed_o (failed_c),
        .exit_valid_o (exit_valid_c), .exit_value_o (exit_value_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b);
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
    endtask

    initial begin
        int idx;
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        req_c = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'hF);

        // Reset state; a request during reset must not be granted
        repeat (2) next();
        req_a = 1'b1;
        req_c = 1'b1;
        drive(1'b1, 32'h100, 32'h1234_5678, 4'hF);
        #1;
        check("rst_gnt_a", gnt_a, 1'b0);
        check("rst_gnt_c", gnt_c, 1'b0);
        check("rst_rvalid_a", rvalid_a, 1'b0);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_passed_a", passed_a, 1'b0);
        check("rst_failed_a", failed_a, 1'b0);
        check("rst_exit_valid_a", exit_valid_a, 1'b0);
        check("rst_exit_value_a", exit_value_a, 32'h0);
        check("rst_rvalid_c", rvalid_c, 1'b0);
        req_a = 1'b0;
        req_c = 1'b0;
        next();
        rst_n = 1'b1;
        next();

        // Write then read back on the zero-stall, latency-1 instance
        req_a = 1'b1;
        drive(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
        #1;
        check("a_wr_gnt", gnt_a, 1'b1);
        check("a_wr_norv", rvalid_a, 1'b0);
        next();
        drive(1'b0, 32'h100, 32'h0, 4'hF);
        #1;
        check("a_rd_gnt", gnt_a, 1'b1);
        check("a_wr_rvalid", rvalid_a, 1'b1);
        check("a_wr_rdata", rdata_a, 32'h0);
        next();
        req_a = 1'b0;
        #1;
        check("a_rd_rvalid", rvalid_a, 1'b1);
        check("a_rd_rdata", rdata_a, 32'hDEAD_BEEF);
        next();
        #1;
        check("a_idle_rvalid", rvalid_a, 1'b0);

        // Byte-enable merge
        req_a = 1'b1;
        drive(1'b1, 32'h104, 32'h1122_3344, 4'hF);
        next();
        drive(1'b1, 32'h104, 32'h0000_AB00, 4'b0010);
        next();
        drive(1'b0, 32'h104, 32'h0, 4'hF);
        next();
        req_a = 1'b0;
        #1;
        check("a_be_rvalid", rvalid_a, 1'b1);
        check("a_be_rdata", rdata_a, 32'h1122_AB44);

        // Virtual registers and unmapped read
        next();
        req_a = 1'b1;
        drive(1'b1, 32'h2000_0000, 32'd123456789, 4'hF);
        next();
        drive(1'b1, 32'h2000_0004, 32'h0000_002A, 4'hF);
        #1;
        check("a_passed", passed_a, 1'b1);
        check("a_failed_clear", failed_a, 1'b0);
        next();
        drive(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        #1;
        check("a_exit_valid", exit_valid_a, 1'b1);
        check("a_exit_value", exit_value_a, 32'h0000_002A);
        next();
        req_a = 1'b0;
        #1;
        check("a_unmapped_rvalid", rvalid_a, 1'b1);
        check("a_unmapped_rdata", rdata_a, 32'h0);
        next();
        #1;
        check("a_unmapped_single", rvalid_a, 1'b0);
        req_a = 1'b1;
        drive(1'b1, 32'h2000_0000, 32'd7, 4'hF);
        next();
        drive(1'b1, 32'h2000_0000, 32'd1, 4'hF);
        #1;
        check("a_other_ignored", failed_a, 1'b0);
        next();
        drive(1'b1, 32'h2000_0004, 32'h0000_0055, 4'hF);
        #1;
        check("a_failed", failed_a, 1'b1);
        check("a_passed_sticky", passed_a, 1'b1);
        next();
        req_a = 1'b0;
        #1;
        check("a_exit_overwrite", exit_value_a, 32'h0000_0055);
        check("a_exit_valid_sticky", exit_valid_a, 1'b1);

        // Grant stall of 3: grant on the 4th cycle of a held request
        next();
        drive(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        req_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("b_stall", gnt_b, (k == 3) ? 1'b1 : 1'b0);
            next();
        end
        // Back-to-back request pays the full stall again
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k == 0) check("b_stall_rvalid", rvalid_b, 1'b1);
            check("b_b2b_stall", gnt_b, (k == 3) ? 1'b1 : 1'b0);
            next();
        end
        // Hold two cycles, drop, re-raise: the stall restarts
        for (int k = 0; k < 2; k++) begin
            #1;
            check("b_pre_drop", gnt_b, 1'b0);
            next();
        end
        req_b = 1'b0;
        #1;
        check("b_drop", gnt_b, 1'b0);
        next();
        req_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("b_restart", gnt_b, (k == 3) ? 1'b1 : 1'b0);
            next();
        end
        req_b = 1'b0;

        // Preload four words into u_c, letting each response drain
        for (int i = 0; i < 4; i++) begin
            req_c = 1'b1;
            drive(1'b1, 32'(i * 4), 32'hC0DE_0000 | 32'(i), 4'hF);
            #1;
            check("c_pre_gnt", gnt_c, 1'b1);
            next();
            req_c = 1'b0;
            repeat (5) next();
        end

        // Four back-to-back reads against a limit of two outstanding
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            req_c = (idx < 4);
            drive(1'b0, 32'(idx * 4), 32'h0, 4'hF);
            #1;
            check("c_gnt", gnt_c, exp_gnt[k]);
            check("c_rvalid", rvalid_c, exp_rv[k]);
            check("c_rdata", rdata_c, exp_rd[k]);
            if (gnt_c) idx++;
            next();
        end
        req_c = 1'b0;

        // Reset with two reads in flight
        req_c = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 4'hF);
        #1;
        check("c_inflight_gnt0", gnt_c, 1'b1);
        next();
        drive(1'b0, 32'h4, 32'h0, 4'hF);
        #1;
        check("c_inflight_gnt1", gnt_c, 1'b1);
        next();
        rst_n = 1'b0;
        #1;
        check("c_rst_gnt", gnt_c, 1'b0);
        next();
        rst_n = 1'b1;
        req_c = 1'b0;
        #1;
        check("post_rst_passed_a", passed_a, 1'b0);
        check("post_rst_failed_a", failed_a, 1'b0);
        check("post_rst_exit_valid_a", exit_valid_a, 1'b0);
        check("post_rst_exit_value_a", exit_value_a, 32'h0);
        for (int k = 0; k < 6; k++) begin
            check("c_rst_norv", rvalid_c, 1'b0);
            next();
            #1;
        end
        // Outstanding cleared: two immediate grants again
        req_c = 1'b1;
        drive(1'b0, 32'h8, 32'h0, 4'hF);
        #1;
        check("c_post_gnt0", gnt_c, 1'b1);
        next();
        drive(1'b0, 32'hC, 32'h0, 4'hF);
        #1;
        check("c_post_gnt1", gnt_c, 1'b1);
        next();
        req_c = 1'b0;
        repeat (2) next();
        #1;
        check("c_post_rv0", rvalid_c, 1'b1);
        check("c_post_rd0", rdata_c, 32'hC0DE_0002);
        next();
        #1;
        check("c_post_rv1", rvalid_c, 1'b1);
        check("c_post_rd1", rdata_c, 32'hC0DE_0003);

        // RAM contents survive reset
        next();
        req_a = 1'b1;
        drive(1'b0, 32'h100, 32'h0, 4'hF);
        next();
        req_a = 1'b0;
        #1;
        check("a_ram_kept_rvalid", rvalid_a, 1'b1);
        check("a_ram_kept_rdata", rdata_a, 32'hDEAD_BEEF);

        next();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscof_obi_stall_responder.md
# riscof_obi_stall_responder

Data-side OBI responder for the RISCOF CV32E40P bench: accepts the core's `data_req_o`/`data_gnt_i`/`data_rvalid_i` transactions, backs them with a word-addressed RAM plus pass/fail/exit virtual registers, and injects fixed grant stall and response latency to stress the core's LSU. Sits between `cv32e40p_core` data port and the bench top, replacing the zero-wait data path when stall testing is enabled. Responses are strictly in order, with bounded outstanding count.

## Interface
- `MEM_ADDR_WIDTH`, 16: byte-address bits decoded to RAM (2^MEM_ADDR_WIDTH bytes).
- `GNT_STALL`, 0: cycles `req_i` must be held before `gnt_o` (0 = same-cycle grant).
- `RVALID_LATENCY`, 1: cycles from grant cycle to `rvalid_o`; legal 1..8.
- `MAX_OUTSTANDING`, 2: granted-but-unanswered limit; legal 1..RVALID_LATENCY+1.
- `clk_i` in 1: the single clock; all state on rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `req_i` in 1: request valid; held with address phase until granted.
- `addr_i` in 32: byte address; bits [1:0] ignored.
- `we_i` in 1: 1 = write.
- `be_i` in 4: byte enables for writes.
- `wdata_i` in 32: write data.
- `gnt_o` out 1: address phase accepted this cycle (combinational).
- `rvalid_o` out 1: response valid, one cycle per transaction.
- `rdata_o` out 32: read data; 0 when `rvalid_o` low or for writes.
- `tests_passed_o` out 1: sticky.
- `tests_failed_o` out 1: sticky.
- `exit_valid_o` out 1: sticky.
- `exit_value_o` out 32: last value written to exit register.

## Operation
- Grant FSM states IDLE, WAIT. IDLE: `req_i` && GNT_STALL>0 -> WAIT, stall counter loads 1. WAIT: counter increments while `req_i`; `req_i` drop -> IDLE, counter clears.
- `gnt_o` = `req_i` && !full && (GNT_STALL==0 ? state IDLE or WAIT : counter==GNT_STALL); grant returns FSM to IDLE. Back-to-back requests each pay the full stall.
- full = outstanding==MAX_OUTSTANDING && !`rvalid_o` (a response retiring this cycle frees a slot).
- Outstanding counter: +1 on grant, -1 on `rvalid_o`, unchanged on both.
- Access performed at grant edge: RAM write of enabled bytes; read data captured from RAM state before the edge, so a write granted one cycle earlier is visible.
- Decode: addr < 2^MEM_ADDR_WIDTH -> RAM; 32'h2000_0000 PASS/FAIL register; 32'h2000_0004 EXIT register; else unmapped.
- PASS/FAIL write: wdata 32'd123456789 sets `tests_passed_o`; wdata 1 sets `tests_failed_o`; other values ignored. EXIT write: `exit_value_o`<=wdata, `exit_valid_o`<=1.
- Reads of registers/unmapped return 0; unmapped writes dropped; every granted transaction still gets exactly one `rvalid_o`.

## Timing
- Grant in cycle t -> `rvalid_o` high in cycle t+RVALID_LATENCY, registered.
- Reset values: `gnt_o` 0 (forced while `rst_ni` low), `rvalid_o` 0, `rdata_o` 0, all flags 0, `exit_value_o` 0, FSM IDLE, counters 0.
- Reset mid-operation: all in-flight responses discarded; no `rvalid_o` for pre-reset grants. RAM contents not reset.
- Sticky flags persist until reset; repeated EXIT writes overwrite value.

## Structure
- Package `riscof_obi_pkg`: PASS_FAIL_ADDR, EXIT_ADDR, PASS_VALUE, FAIL_VALUE constants; `obi_rsp_t` struct {valid, rdata[31:0]}.
- Sub-module `riscof_obi_rsp_delay`: RVALID_LATENCY-stage shift register of `obi_rsp_t`, synchronous clear.
- RAM as inline array with per-byte write.

## Test plan
- GNT_STALL=0, RVALID_LATENCY=1: write 0xDEADBEEF to 0x100, read 0x100 next cycle -> gnt same cycle, rvalid 1 cycle later, rdata 0xDEADBEEF.
- GNT_STALL=3: hold req -> gnt on 4th cycle; drop req after 2 cycles then re-raise -> counter restarts, no gnt before 3 more cycles.
- RVALID_LATENCY=4, MAX_OUTSTANDING=2: 4 back-to-back reads -> gnt on cycles 0,1, stalled until first rvalid (cycle 4), then 3rd gnt same cycle; responses in order.
- Write be=4'b0010 data 0x0000AB00 over 0x11223344 -> read returns 0x1122AB44.
- Write 123456789 to 0x2000_0000 and 0x2A to 0x2000_0004 -> tests_passed_o=1, exit_valid_o=1, exit_value_o=0x2A; read unmapped 0x3000_0000 -> rdata 0, one rvalid.
- Assert rst_ni low for 1 cycle with 2 outstanding -> no rvalid afterwards, outstanding 0, flags cleared, RAM data intact.
